lsu_mem_master: RTL and testbench

Load/store initiator between the RV32IC core's memory stage and the word-wide data memory. It accepts one RV32I load or store from the core and drives the memory's read/write strobes, word address and write data. Sub-word stores are handled as read-modify-write, because the memory has no byte enables. Load results are returned byte/halfword-extracted and sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_mem_master_if.sv | 31 +++
 rtl/lsu_align.sv | 57 +++++
 rtl/lsu_mem_master.sv | 110 +++++++++++
 tb/tb_lsu_mem_master.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: RV32I funct3 codes,
// FSM state encoding and a small access-size helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    // funct3[1:0] encodes access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Bundles the core request/response signals and the data-memory port of the
// load/store master; master modport is the LSU view, slave the environment view.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 6
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              fault;
    logic [31:0]       rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output busy, done, fault, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  busy, done, fault, rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte/halfword lane logic: load extract/extend, store merge for
// read-modify-write, and illegal/misaligned request detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  op_off,
    input  logic [2:0]  op_funct3,
    input  logic        chk_we,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_off,
    output logic [31:0] ld_result,
    output logic [31:0] st_merged,
    output logic        chk_fault
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        ld_byte = ld_word[{op_off, 3'b000} +: 8];
        ld_half = ld_word[{op_off[1], 4'b0000} +: 16];
        case (op_funct3)
            F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_result = {24'h0, ld_byte};
            F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_result = {16'h0, ld_half};
            default: ld_result = ld_word;
        endcase
    end

    // Sub-word stores overwrite only their lane of the word read back in RD.
    always_comb begin
        st_merged = st_word;
        case (op_funct3)
            F3_B:    st_merged[{op_off, 3'b000} +: 8]      = st_data[7:0];
            F3_H:    st_merged[{op_off[1], 4'b0000} +: 16] = st_data[15:0];
            default: st_merged = st_data;
        endcase
    end

    always_comb begin
        if (chk_we) begin
            illegal = !(chk_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(chk_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        misaligned = ((f3_size(chk_funct3) == 2'b01) && chk_off[0]) ||
                     ((f3_size(chk_funct3) == 2'b10) && (chk_off != 2'b00));
        chk_fault  = illegal || misaligned;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one RV32I load/store, drives the word-wide
// data memory (sub-word stores via read-modify-write) and returns the result.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_mem_master_if.master    bus
);

    lsu_state_e          state_q,  state_d;
    logic                we_q,     we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W+1:0]   addr_q,   addr_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [31:0]         word_q,   word_d;
    logic [31:0]         rdata_q,  rdata_d;

    logic [31:0]         ld_result;
    logic [31:0]         st_merged;
    logic                chk_fault;

    lsu_align u_align (
        .ld_word    (bus.mem_rdata),
        .st_word    (word_q),
        .st_data    (wdata_q),
        .op_off     (addr_q[1:0]),
        .op_funct3  (funct3_q),
        .chk_we     (bus.we),
        .chk_funct3 (bus.funct3),
        .chk_off    (bus.addr[1:0]),
        .ld_result  (ld_result),
        .st_merged  (st_merged),
        .chk_fault  (chk_fault)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d     = bus.we;
                    funct3_d = bus.funct3;
                    addr_d   = bus.addr[ADDR_W+1:0];
                    wdata_d  = bus.wdata;
                    if (chk_fault) begin
                        state_d = ST_ERR;
                    end else if (!bus.we || (bus.funct3 != F3_W)) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            // Loads extract straight from the returned word so rdata is valid in DONE.
            ST_RD: begin
                word_d = bus.mem_rdata;
                if (we_q) begin
                    state_d = ST_WR;
                end else begin
                    rdata_d = ld_result;
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign bus.fault     = (state_q == ST_ERR);
    assign bus.rdata     = rdata_q;
    assign bus.mem_read  = (state_q == ST_RD);
    assign bus.mem_write = (state_q == ST_WR);
    assign bus.mem_addr  = ((state_q == ST_RD) || (state_q == ST_WR)) ? addr_q[ADDR_W+1:2] : '0;
    assign bus.mem_wdata = (state_q == ST_WR) ? st_merged : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table of single operations plus
// hand-written sequences for held requests and reset during a write.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    localparam int ADDR_W = 6;

    logic clk;
    logic rst_n;
    logic mem_init;
    logic [31:0] mem [64];

    int checks;
    int errors;

    lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000_0011;
            mem[1] <= 32'h0000_0009;
            mem[2] <= 32'h0000_0019;
            mem[4] <= 32'h8070_FF80;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        fault;
        logic [31:0] rdata;
        int          n_rd;
        int          n_wr;
        logic [5:0]  maddr;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int lat, n_rd, n_wr, both, idle_addr;
        logic [5:0]  rd_addr, wr_addr;
        logic [31:0] wd, got_rdata;
        logic        got_fault;
        string       tag;
        lat = 0; n_rd = 0; n_wr = 0; both = 0; idle_addr = 0;
        rd_addr = '0; wr_addr = '0; wd = '0; got_rdata = '0; got_fault = 1'b0;
        @(negedge clk);
        bus.we = v.we; bus.funct3 = v.f3; bus.addr = v.addr; bus.wdata = v.wdata;
        bus.req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_read)  begin n_rd++; rd_addr = bus.mem_addr; end
            if (bus.mem_write) begin n_wr++; wr_addr = bus.mem_addr; wd = bus.mem_wdata; end
            if (bus.mem_read && bus.mem_write) both++;
            if (!bus.mem_read && !bus.mem_write && bus.mem_addr != '0) idle_addr++;
            if (bus.done) begin
                lat = c; got_fault = bus.fault; got_rdata = bus.rdata;
                break;
            end
        end
        bus.req = 1'b0;
        tag = $sformatf("v%0d", idx);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " fault"}, {31'h0, got_fault}, {31'h0, v.fault});
        check({tag, " rdata"}, got_rdata, v.rdata);
        check({tag, " read_cycles"}, n_rd, v.n_rd);
        check({tag, " write_cycles"}, n_wr, v.n_wr);
        check({tag, " strobe_overlap"}, both, 0);
        check({tag, " idle_mem_addr"}, idle_addr, 0);
        if (v.n_rd > 0) check({tag, " read_addr"}, {26'h0, rd_addr}, {26'h0, v.maddr});
        if (v.n_wr > 0) begin
            check({tag, " write_addr"}, {26'h0, wr_addr}, {26'h0, v.maddr});
            check({tag, " write_data"}, wd, v.mwdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        checks = 0; errors = 0;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
        rst_n = 1'b0; mem_init = 1'b1;

        //            we  f3      addr          wdata         lat flt rdata         rd wr ma  mwdata
        vecs[0]  = '{1'b0, F3_W,  32'h0000_0008, 32'h0,         2, 1'b0, 32'h0000_0019, 1, 0, 6'd2, 32'h0};
        vecs[1]  = '{1'b0, F3_B,  32'h0000_0010, 32'h0,         2, 1'b0, 32'hFFFF_FF80, 1, 0, 6'd4, 32'h0};
        vecs[2]  = '{1'b0, F3_BU, 32'h0000_0010, 32'h0,         2, 1'b0, 32'h0000_0080, 1, 0, 6'd4, 32'h0};
        vecs[3]  = '{1'b0, F3_H,  32'h0000_0012, 32'h0,         2, 1'b0, 32'hFFFF_8070, 1, 0, 6'd4, 32'h0};
        vecs[4]  = '{1'b0, F3_HU, 32'h0000_0012, 32'h0,         2, 1'b0, 32'h0000_8070, 1, 0, 6'd4, 32'h0};
        vecs[5]  = '{1'b1, F3_B,  32'h0000_0005, 32'h0000_00AB, 3, 1'b0, 32'h0000_8070, 1, 1, 6'd1, 32'h0000_AB09};
        vecs[6]  = '{1'b0, F3_W,  32'h0000_0004, 32'h0,         2, 1'b0, 32'h0000_AB09, 1, 0, 6'd1, 32'h0};
        vecs[7]  = '{1'b0, F3_H,  32'h0000_0003, 32'h0,         1, 1'b1, 32'h0000_AB09, 0, 0, 6'd0, 32'h0};
        vecs[8]  = '{1'b1, F3_W,  32'h0000_0002, 32'h0000_1234, 1, 1'b1, 32'h0000_AB09, 0, 0, 6'd0, 32'h0};
        vecs[9]  = '{1'b1, F3_W,  32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_AB09, 0, 1, 6'd1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, F3_W,  32'h0000_0004, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 1, 0, 6'd1, 32'h0};
        vecs[11] = '{1'b1, F3_H,  32'h0000_0006, 32'hFFFF_1234, 3, 1'b0, 32'hDEAD_BEEF, 1, 1, 6'd1, 32'h1234_BEEF};
        vecs[12] = '{1'b0, F3_HU, 32'h0000_0006, 32'h0,         2, 1'b0, 32'h0000_1234, 1, 0, 6'd1, 32'h0};
        vecs[13] = '{1'b0, 3'b011,32'h0000_0000, 32'h0,         1, 1'b1, 32'h0000_1234, 0, 0, 6'd0, 32'h0};
        vecs[14] = '{1'b1, F3_BU, 32'h0000_0000, 32'h0,         1, 1'b1, 32'h0000_1234, 0, 0, 6'd0, 32'h0};
        vecs[15] = '{1'b0, F3_BU, 32'h0000_0013, 32'h0,         2, 1'b0, 32'h0000_0080, 1, 0, 6'd4, 32'h0};
        vecs[16] = '{1'b0, F3_B,  32'h0000_0011, 32'h0,         2, 1'b0, 32'hFFFF_FFFF, 1, 0, 6'd4, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'h0, bus.busy}, 32'h0);
        check("reset done", {31'h0, bus.done}, 32'h0);
        check("reset fault", {31'h0, bus.fault}, 32'h0);
        check("reset mem_read", {31'h0, bus.mem_read}, 32'h0);
        check("reset mem_write", {31'h0, bus.mem_write}, 32'h0);
        check("reset rdata", bus.rdata, 32'h0);
        check("reset mem_addr", {26'h0, bus.mem_addr}, 32'h0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; mem_init = 1'b0;

        for (int i = 0; i < 17; i++) run_op(vecs[i], i);
        check("word0 after faults", mem[0], 32'h0000_0011);
        check("word1 final", mem[1], 32'h1234_BEEF);

        // Request held high across busy: second op starts only after done.
        @(negedge clk);
        bus.we = 1'b0; bus.funct3 = F3_W; bus.addr = 32'h0; bus.req = 1'b1;
        @(negedge clk);
        check("held c1 busy", {31'h0, bus.busy}, 32'h1);
        check("held c1 done", {31'h0, bus.done}, 32'h0);
        bus.addr = 32'h10;
        @(negedge clk);
        check("held c2 done", {31'h0, bus.done}, 32'h1);
        check("held c2 rdata", bus.rdata, 32'h0000_0011);
        bus.addr = 32'h8;
        @(negedge clk);
        check("held c3 busy", {31'h0, bus.busy}, 32'h0);
        check("held c3 done", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        check("held c4 busy", {31'h0, bus.busy}, 32'h1);
        check("held c4 done", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        check("held c5 done", {31'h0, bus.done}, 32'h1);
        check("held c5 rdata", bus.rdata, 32'h0000_0019);
        bus.req = 1'b0;

        // Reset asserted mid-WR: strobe must drop before the edge, no write, no done.
        @(negedge clk);
        bus.we = 1'b1; bus.funct3 = F3_W; bus.addr = 32'h0; bus.wdata = 32'h0000_0055; bus.req = 1'b1;
        @(negedge clk);
        check("abort wr strobe", {31'h0, bus.mem_write}, 32'h1);
        bus.req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort strobe drop", {31'h0, bus.mem_write}, 32'h0);
        check("abort busy", {31'h0, bus.busy}, 32'h0);
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (bus.done) done_seen++;
        end
        check("abort no done", done_seen, 0);
        check("abort word0 intact", mem[0], 32'h0000_0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
